hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Sits beside ID, upstream of the forwarding selectors.
- Decides when PC and IF/ID must freeze and when ID/EXE receives a bubble, so that every dependency reaching the forwarding unit is one it can actually resolve.
- Also squashes the fetched instruction after a taken branch or jump, and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of the stall and flush performance counters (saturating)

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  6  opcode of instruction in ID
rs  input  5  ID source register rs
rt  input  5  ID source register rt
EXE_num_write  input  5  destination register of instruction in EXE
EXE_reg_write  input  1  EXE instruction writes register file
EXE_s_data_write  input  2  EXE writeback source select; 2'b01 = data-memory load
MEM_num_write  input  5  destination register of instruction in MEM
MEM_reg_write  input  1  MEM instruction writes register file
MEM_s_data_write  input  2  MEM writeback source select; 2'b01 = load
branch_taken  input  1  ID branch/jump resolved taken (beq equal, j, jal, jr)
pc_write  output  1  1 = PC may update
IF_ID_write  output  1  1 = IF/ID register may load
IF_ID_flush  output  1  1 = IF/ID loads a nop next edge
ID_EXE_flush  output  1  1 = ID/EXE loads a bubble (all write enables 0)
stall_cycles  output  CNT_W  count of stall cycles since reset
flush_count  output  CNT_W  count of IF/ID flushes since reset

Behaviour:
- Reset (async, rst_n=0): FSM = RUN, hold counter = 0, stall_cycles = 0, flush_count = 0.
- Combinational outputs at reset follow RUN equations.
- uses_rs: op != 6'b000010 (j) and op != 6'b000011 (jal).
- uses_rt: op is 6'b000000, 6'b000100 or 6'b101011.
- Register 0 never causes a hazard.
- Match: a source register equals the stage's num_write, that stage's reg_write=1, and the register is non-zero.
- Required stalls n, computed in RUN:
  - Load-use: EXE is a load and matches rs/rt → n=1.
  - beq (op 6'b000100) with EXE load match → n=2.
  - beq with EXE non-load match → n=1.
  - beq with MEM load match → n=1.
  - Otherwise n=0. When several conditions hold, n is the maximum.
- FSM:
  - RUN, n=0: stall=0.
  - RUN, n=1: stall=1 this cycle, stay in RUN. The hazard re-evaluates next cycle against the advanced pipeline.
  - RUN, n=2: stall=1, go to HOLD.
  - HOLD: stall=1 unconditionally, return to RUN next edge. Inputs are ignored in HOLD.
- Output equations:
  - pc_write = IF_ID_write = ~stall.
  - ID_EXE_flush = stall.
  - IF_ID_flush = branch_taken & ~stall. branch_taken is ignored while stalling because operands are not yet valid.
- Latency: outputs are Mealy, valid in the same cycle as the inputs. No registered delay except the HOLD state.
- Counters:
  - stall_cycles increments on each edge where stall=1.
  - flush_count increments on each edge where IF_ID_flush=1.
  - Both saturate at all-ones and do not wrap.
- Reset asserted in HOLD forces RUN immediately, deasserting stall in the same cycle.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_J, OP_JAL, OP_SW;
  - writeback-select constant WB_SRC_MEM = 2'b01;
  - FSM state encoding RUN/HOLD.
- One sub-module: sat_counter (CNT_W, enable input, saturating, async active-low reset), instantiated twice.

Test Plan:
- Load-use: EXE lw $8 (reg_write=1, s_data_write=01), ID add with rs=8 → one cycle with pc_write=0, IF_ID_write=0, ID_EXE_flush=1; next cycle all 1/1/0; stall_cycles=1.
- Branch after load: EXE lw $9, ID beq rs=9 → two consecutive stall cycles (second in HOLD, even if inputs are changed to no-match); stall_cycles=2.
- Branch after ALU: EXE add $5, ID beq rt=5 → exactly one stall cycle. Same stimulus with rt=0 and EXE_num_write=0 → no stall.
- Non-user of rt: EXE lw $6, ID addi (op 001000) with rt=6, rs=1 → no stall.
- Taken branch: branch_taken=1, no hazard → IF_ID_flush=1 for one cycle, flush_count=1. branch_taken=1 during a load-use stall → IF_ID_flush=0.
- Reset in HOLD: pull rst_n low in the second beq stall cycle → state RUN, stall=0, counters=0 immediately. Force counters to all-ones, then stall → values hold at all-ones.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the ID-stage hazard/stall controller.
package hazard_ctrl_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned WB_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [WB_W-1:0] WB_SRC_MEM = 2'b01;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A source register depends on a stage only if that stage really writes it; $0 never does.
  function automatic logic reg_match(input logic             used,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic             we);
    return used && we && (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals seen and driven by the hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] EXE_num_write;
  logic             EXE_reg_write;
  logic [WB_W-1:0]  EXE_s_data_write;
  logic [REG_W-1:0] MEM_num_write;
  logic             MEM_reg_write;
  logic [WB_W-1:0]  MEM_s_data_write;
  logic             branch_taken;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EXE_flush;

  modport master (
    output op, rs, rt,
    output EXE_num_write, EXE_reg_write, EXE_s_data_write,
    output MEM_num_write, MEM_reg_write, MEM_s_data_write,
    output branch_taken,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EXE_flush
  );

  modport slave (
    input  op, rs, rt,
    input  EXE_num_write, EXE_reg_write, EXE_s_data_write,
    input  MEM_num_write, MEM_reg_write, MEM_s_data_write,
    input  branch_taken,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EXE_flush
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Freezes PC/IF-ID and bubbles ID/EXE until every ID dependency is forwardable;
// squashes the fetched instruction behind a taken branch or jump.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  hazard_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_stall;
  logic   w_if_id_flush;

  logic   w_uses_rs;
  logic   w_uses_rt;
  logic   w_is_beq;
  logic   w_exe_match;
  logic   w_mem_match;
  logic   w_exe_load;
  logic   w_mem_load;
  logic   w_need2;
  logic   w_need1;

  assign w_uses_rs = (bus.op != OP_J) && (bus.op != OP_JAL);
  assign w_uses_rt = (bus.op == OP_RTYPE) || (bus.op == OP_BEQ) || (bus.op == OP_SW);
  assign w_is_beq  = (bus.op == OP_BEQ);

  assign w_exe_match = reg_match(w_uses_rs, bus.rs, bus.EXE_num_write, bus.EXE_reg_write) ||
                       reg_match(w_uses_rt, bus.rt, bus.EXE_num_write, bus.EXE_reg_write);
  assign w_mem_match = reg_match(w_uses_rs, bus.rs, bus.MEM_num_write, bus.MEM_reg_write) ||
                       reg_match(w_uses_rt, bus.rt, bus.MEM_num_write, bus.MEM_reg_write);
  assign w_exe_load  = (bus.EXE_s_data_write == WB_SRC_MEM);
  assign w_mem_load  = (bus.MEM_s_data_write == WB_SRC_MEM);

  // beq compares in ID, so it waits for ALU results and loads one stage longer than other users.
  assign w_need2 = w_is_beq && w_exe_match && w_exe_load;
  assign w_need1 = (w_exe_match && w_exe_load) ||
                   (w_is_beq && w_exe_match) ||
                   (w_is_beq && w_mem_match && w_mem_load);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Single-cycle hazards re-evaluate each cycle in RUN; only the two-cycle case needs HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_need2) begin
          w_stall     = 1'b1;
          w_state_nxt = HOLD;
        end else if (w_need1) begin
          w_stall     = 1'b1;
        end
      end
      HOLD: begin
        w_stall     = 1'b1;
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Branch outcome depends on operands that are not ready while stalling.
  assign w_if_id_flush = bus.branch_taken && !w_stall;

  assign bus.pc_write     = !w_stall;
  assign bus.IF_ID_write  = !w_stall;
  assign bus.ID_EXE_flush = w_stall;
  assign bus.IF_ID_flush  = w_if_id_flush;

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clock),
    .rst_n   (rst_n),
    .i_en    (w_stall),
    .o_count (stall_cycles)
  );

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clock),
    .rst_n   (rst_n),
    .i_en    (w_if_id_flush),
    .o_count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with narrow counters so saturation is reachable.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clock;
  logic             rst_n;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  int               n_checks;
  int               n_fail;

  hazard_ctrl_if u_if ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .bus          (u_if),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic exp_stall, input logic exp_iflush);
    chk({tag, ".pc_write"},     32'(u_if.pc_write),     32'(!exp_stall));
    chk({tag, ".IF_ID_write"},  32'(u_if.IF_ID_write),  32'(!exp_stall));
    chk({tag, ".ID_EXE_flush"}, 32'(u_if.ID_EXE_flush), 32'(exp_stall));
    chk({tag, ".IF_ID_flush"},  32'(u_if.IF_ID_flush),  32'(exp_iflush));
  endtask

  task automatic idle();
    u_if.op               = OP_RTYPE;
    u_if.rs               = '0;
    u_if.rt               = '0;
    u_if.EXE_num_write    = '0;
    u_if.EXE_reg_write    = 1'b0;
    u_if.EXE_s_data_write = 2'b00;
    u_if.MEM_num_write    = '0;
    u_if.MEM_reg_write    = 1'b0;
    u_if.MEM_s_data_write = 2'b00;
    u_if.branch_taken     = 1'b0;
  endtask

  task automatic exe_wr(input logic [4:0] dst, input logic is_load);
    u_if.EXE_num_write    = dst;
    u_if.EXE_reg_write    = 1'b1;
    u_if.EXE_s_data_write = is_load ? WB_SRC_MEM : 2'b00;
  endtask

  // Inputs are driven just after the falling edge and sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    #3;
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset.flush_count",  32'(flush_count),  32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    step();

    // Load-use: lw $8 in EXE, add rs=8 in ID
    exe_wr(5'd8, 1'b1);
    u_if.rs = 5'd8;
    #1 chk_ctl("loaduse.stall", 1'b1, 1'b0);
    step();
    idle();
    u_if.rs = 5'd8;
    u_if.MEM_num_write = 5'd8; u_if.MEM_reg_write = 1'b1; u_if.MEM_s_data_write = WB_SRC_MEM;
    #1 chk_ctl("loaduse.after", 1'b0, 1'b0);
    chk("loaduse.stall_cycles", 32'(stall_cycles), 32'd1);
    step();

    // beq after load: two stall cycles, second one ignores inputs
    idle();
    exe_wr(5'd9, 1'b1);
    u_if.op = OP_BEQ; u_if.rs = 5'd9;
    #1 chk_ctl("beqld.c1", 1'b1, 1'b0);
    step();
    idle();
    #1 chk_ctl("beqld.hold", 1'b1, 1'b0);
    step();
    #1 chk_ctl("beqld.done", 1'b0, 1'b0);
    chk("beqld.stall_cycles", 32'(stall_cycles), 32'd3);

    // beq after ALU producer on rt: one stall
    exe_wr(5'd5, 1'b0);
    u_if.op = OP_BEQ; u_if.rt = 5'd5;
    #1 chk_ctl("beqalu.c1", 1'b1, 1'b0);
    step();
    idle();
    #1 chk_ctl("beqalu.done", 1'b0, 1'b0);
    chk("beqalu.stall_cycles", 32'(stall_cycles), 32'd4);
    // $0 never hazards
    exe_wr(5'd0, 1'b0);
    u_if.op = OP_BEQ; u_if.rt = 5'd0;
    #1 chk_ctl("beqzero", 1'b0, 1'b0);
    step();

    // beq behind a load now in MEM: one stall
    idle();
    u_if.op = OP_BEQ; u_if.rs = 5'd7;
    u_if.MEM_num_write = 5'd7; u_if.MEM_reg_write = 1'b1; u_if.MEM_s_data_write = WB_SRC_MEM;
    #1 chk_ctl("beqmem", 1'b1, 1'b0);
    step();

    // addi does not read rt
    idle();
    exe_wr(5'd6, 1'b1);
    u_if.op = 6'b001000; u_if.rt = 5'd6; u_if.rs = 5'd1;
    #1 chk_ctl("addi_rt", 1'b0, 1'b0);
    step();
    chk("addi.stall_cycles", 32'(stall_cycles), 32'd5);

    // Taken branch without hazard squashes IF/ID
    idle();
    u_if.branch_taken = 1'b1;
    #1 chk_ctl("taken", 1'b0, 1'b1);
    step();
    u_if.branch_taken = 1'b0;
    #1 chk_ctl("taken.after", 1'b0, 1'b0);
    chk("taken.flush_count", 32'(flush_count), 32'd1);
    // Taken during load-use stall is ignored
    exe_wr(5'd8, 1'b1);
    u_if.rs = 5'd8;
    u_if.branch_taken = 1'b1;
    #1 chk_ctl("taken_stall", 1'b1, 1'b0);
    step();
    chk("taken_stall.flush_count",  32'(flush_count),  32'd1);
    chk("taken_stall.stall_cycles", 32'(stall_cycles), 32'd6);

    // Reset asserted in HOLD
    idle();
    exe_wr(5'd9, 1'b1);
    u_if.op = OP_BEQ; u_if.rs = 5'd9;
    step();
    idle();
    #1 chk_ctl("rsthold.pre", 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 chk_ctl("rsthold.rst", 1'b0, 1'b0);
    chk("rsthold.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rsthold.flush_count",  32'(flush_count),  32'd0);
    #1 rst_n = 1'b1;
    step();
    #1 chk_ctl("rsthold.run", 1'b0, 1'b0);
    chk("rsthold.cnt_after", 32'(stall_cycles), 32'd0);

    // Saturation of both counters
    exe_wr(5'd3, 1'b1);
    u_if.rs = 5'd3;
    for (int i = 0; i < 14; i++) step();
    chk("sat.stall14", 32'(stall_cycles), 32'd14);
    for (int i = 0; i < 3; i++) step();
    #1 chk_ctl("sat.still_stall", 1'b1, 1'b0);
    chk("sat.stall_max", 32'(stall_cycles), 32'd15);
    idle();
    u_if.branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) step();
    chk("sat.flush_max", 32'(flush_count),  32'd15);
    chk("sat.stall_hold", 32'(stall_cycles), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
